// File: rtl/memwb_seq.sv
// MEM/WB pipeline stage sequencer: holds one instruction's payload and walks it
// through up to MAX_ACC memory accesses, with a one-cycle gap between accesses.
module memwb_seq #(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned CTRL_W  = 32,
  parameter  int unsigned MAX_ACC = 2,
  localparam int unsigned CNT_W   = $clog2(MAX_ACC + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [2:0]        dest_in,
  input  logic [CNT_W-1:0]  acc_cnt_in,
  input  logic [MAX_ACC-1:0] rd_mask_in,
  input  logic              data_response,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic [2:0]        dest_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic [CNT_W-1:0]  acc_idx,
  output logic [DATA_W-1:0] rdata_out,
  output logic              ready
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [MAX_ACC-1:0] rd_mask_q;
  logic [MAX_ACC-1:0] mask_sh;
  logic [CNT_W-1:0]   cnt_sat;
  logic               cur_read;
  logic               last_acc;
  logic               take;
  logic               resp;

  // Requested access count is clamped so oversize requests still terminate.
  assign cnt_sat  = (acc_cnt_in > CNT_W'(MAX_ACC)) ? CNT_W'(MAX_ACC) : acc_cnt_in;
  assign mask_sh  = rd_mask_q >> acc_idx;
  assign cur_read = mask_sh[0];
  assign last_acc = (acc_idx + CNT_W'(1)) == cnt_q;
  assign take     = (state_q == IDLE) && advance && !flush;
  assign resp     = (state_q == REQ) && data_response && !flush;

  always_comb begin
    state_d   = state_q;
    ready     = (state_q == IDLE);
    mem_read  = (state_q == REQ) && cur_read;
    mem_write = (state_q == REQ) && !cur_read;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (advance) state_d = (valid_in && (cnt_sat != '0)) ? REQ : IDLE;
        REQ:     if (data_response) state_d = last_acc ? IDLE : GAP;
        GAP:     state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_mask_q <= '0;
      valid_out <= 1'b0;
      ctrl_out  <= '0;
      pc_out    <= '0;
      alu_out   <= '0;
      wdata_out <= '0;
      dest_out  <= '0;
      acc_idx   <= '0;
      rdata_out <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        valid_out <= 1'b0;
        ctrl_out  <= '0;
        acc_idx   <= '0;
      end else if (take) begin
        valid_out <= valid_in;
        ctrl_out  <= ctrl_in;
        pc_out    <= pc_in;
        alu_out   <= alu_in;
        wdata_out <= wdata_in;
        dest_out  <= dest_in;
        cnt_q     <= cnt_sat;
        rd_mask_q <= rd_mask_in;
        acc_idx   <= '0;
      end else if (resp) begin
        if (cur_read) rdata_out <= mem_rdata;
        if (!last_acc) acc_idx <= acc_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_memwb_seq.sv
// Directed self-checking bench for memwb_seq with the default parameters
// (DATA_W=16, CTRL_W=32, MAX_ACC=2, so acc_cnt_in is 2 bits wide).
module tb_memwb_seq;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CTRL_W  = 32;
  localparam int unsigned MAX_ACC = 2;
  localparam int unsigned CNT_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              advance, flush, valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] pc_in, alu_in, wdata_in;
  logic [2:0]        dest_in;
  logic [CNT_W-1:0]  acc_cnt_in;
  logic [MAX_ACC-1:0] rd_mask_in;
  logic              data_response;
  logic [DATA_W-1:0] mem_rdata;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] pc_out, alu_out, wdata_out;
  logic [2:0]        dest_out;
  logic              mem_read, mem_write;
  logic [CNT_W-1:0]  acc_idx;
  logic [DATA_W-1:0] rdata_out;
  logic              ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  memwb_seq #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .MAX_ACC(MAX_ACC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .advance      (advance),
    .flush        (flush),
    .valid_in     (valid_in),
    .ctrl_in      (ctrl_in),
    .pc_in        (pc_in),
    .alu_in       (alu_in),
    .wdata_in     (wdata_in),
    .dest_in      (dest_in),
    .acc_cnt_in   (acc_cnt_in),
    .rd_mask_in   (rd_mask_in),
    .data_response(data_response),
    .mem_rdata    (mem_rdata),
    .valid_out    (valid_out),
    .ctrl_out     (ctrl_out),
    .pc_out       (pc_out),
    .alu_out      (alu_out),
    .wdata_out    (wdata_out),
    .dest_out     (dest_out),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .acc_idx      (acc_idx),
    .rdata_out    (rdata_out),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic rd, input logic wr, input logic rdy);
    chk({tag, "_rd"}, {31'd0, mem_read}, {31'd0, rd});
    chk({tag, "_wr"}, {31'd0, mem_write}, {31'd0, wr});
    chk({tag, "_rdy"}, {31'd0, ready}, {31'd0, rdy});
  endtask

  initial begin
    reset = 1'b1; advance = 0; flush = 0; valid_in = 0;
    ctrl_in = '0; pc_in = '0; alu_in = '0; wdata_in = '0; dest_in = '0;
    acc_cnt_in = '0; rd_mask_in = '0; data_response = 0; mem_rdata = '0;

    // Reset state
    #3;
    strobes("rst", 0, 0, 1);
    chk("rst_valid", {31'd0, valid_out}, 0);
    chk("rst_alu", {16'd0, alu_out}, 0);
    chk("rst_rdata", {16'd0, rdata_out}, 0);
    tick(); tick();
    reset = 1'b0;

    // No-access instruction passes straight through
    valid_in = 1; ctrl_in = 32'hA5A5_0001; pc_in = 16'h0100; alu_in = 16'h1234;
    wdata_in = 16'h5555; dest_in = 3'd3; acc_cnt_in = 2'd0; rd_mask_in = 2'b00; advance = 1;
    tick(); advance = 0;
    chk("t1_alu", {16'd0, alu_out}, 32'h1234);
    chk("t1_pc", {16'd0, pc_out}, 32'h0100);
    chk("t1_ctrl", ctrl_out, 32'hA5A5_0001);
    chk("t1_dest", {29'd0, dest_out}, 3);
    chk("t1_valid", {31'd0, valid_out}, 1);
    strobes("t1", 0, 0, 1);

    // Single read waits for response
    acc_cnt_in = 2'd1; rd_mask_in = 2'b01; alu_in = 16'h2000; advance = 1;
    tick(); advance = 0;
    strobes("t2a", 1, 0, 0);
    chk("t2a_idx", {30'd0, acc_idx}, 0);
    tick();
    strobes("t2b", 1, 0, 0);
    data_response = 1; mem_rdata = 16'hBEEF;
    tick(); data_response = 0;
    chk("t2_rdata", {16'd0, rdata_out}, 32'hBEEF);
    strobes("t2c", 0, 0, 1);

    // Indirect load: read, gap, read
    acc_cnt_in = 2'd2; rd_mask_in = 2'b11; alu_in = 16'h2100; advance = 1;
    tick(); advance = 0;
    strobes("t3a", 1, 0, 0);
    data_response = 1; mem_rdata = 16'h1111;
    tick();
    strobes("t3gap", 0, 0, 0);
    chk("t3gap_idx", {30'd0, acc_idx}, 1);
    chk("t3gap_rdata", {16'd0, rdata_out}, 32'h1111);
    mem_rdata = 16'h9999;  // response during GAP must be ignored
    tick();
    strobes("t3b", 1, 0, 0);
    chk("t3b_rdata", {16'd0, rdata_out}, 32'h1111);
    mem_rdata = 16'h2222;
    tick(); data_response = 0;
    strobes("t3c", 0, 0, 1);
    chk("t3c_rdata", {16'd0, rdata_out}, 32'h2222);
    chk("t3c_idx", {30'd0, acc_idx}, 1);

    // Indirect store: read then write
    acc_cnt_in = 2'd2; rd_mask_in = 2'b01; wdata_in = 16'h7777; advance = 1;
    tick(); advance = 0;
    strobes("t4a", 1, 0, 0);
    data_response = 1; mem_rdata = 16'h3333;
    tick(); data_response = 0;
    strobes("t4gap", 0, 0, 0);
    tick();
    strobes("t4b", 0, 1, 0);
    data_response = 1; mem_rdata = 16'h4444;
    tick(); data_response = 0;
    strobes("t4c", 0, 0, 1);
    chk("t4_rdata", {16'd0, rdata_out}, 32'h3333);
    chk("t4_wdata", {16'd0, wdata_out}, 32'h7777);

    // Flush during REQ, with same-cycle advance and response
    acc_cnt_in = 2'd2; rd_mask_in = 2'b11; ctrl_in = 32'h0000_C0DE; alu_in = 16'h3000; advance = 1;
    tick(); advance = 0;
    chk("t5_ctrl_pre", ctrl_out, 32'h0000_C0DE);
    strobes("t5a", 1, 0, 0);
    flush = 1; advance = 1; data_response = 1; mem_rdata = 16'h5555; alu_in = 16'hDEAD;
    tick(); flush = 0; advance = 0; data_response = 0;
    strobes("t5b", 0, 0, 1);
    chk("t5_valid", {31'd0, valid_out}, 0);
    chk("t5_ctrl", ctrl_out, 0);
    chk("t5_alu", {16'd0, alu_out}, 32'h3000);
    chk("t5_rdata", {16'd0, rdata_out}, 32'h3333);
    data_response = 1; mem_rdata = 16'h6666;
    tick(); data_response = 0;
    chk("t5_late_rdata", {16'd0, rdata_out}, 32'h3333);
    strobes("t5c", 0, 0, 1);

    // Oversize count clamps to MAX_ACC; advance while busy ignored
    valid_in = 1; acc_cnt_in = 2'd3; rd_mask_in = 2'b11; alu_in = 16'h4000; advance = 1;
    tick(); advance = 0;
    strobes("t6a", 1, 0, 0);
    valid_in = 0; alu_in = 16'h4BAD; advance = 1;
    tick(); advance = 0;
    chk("t6_hold_alu", {16'd0, alu_out}, 32'h4000);
    chk("t6_hold_valid", {31'd0, valid_out}, 1);
    strobes("t6b", 1, 0, 0);
    data_response = 1; mem_rdata = 16'h00A1;
    tick(); data_response = 0;
    tick();
    strobes("t6c", 1, 0, 0);
    chk("t6c_idx", {30'd0, acc_idx}, 1);
    data_response = 1; mem_rdata = 16'h00A2;
    tick(); data_response = 0;
    strobes("t6d", 0, 0, 1);
    chk("t6_rdata", {16'd0, rdata_out}, 32'h00A2);

    // Bubble with nonzero count does not start accesses
    valid_in = 0; acc_cnt_in = 2'd1; alu_in = 16'h5000; advance = 1;
    tick(); advance = 0;
    strobes("t7", 0, 0, 1);
    chk("t7_valid", {31'd0, valid_out}, 0);
    chk("t7_alu", {16'd0, alu_out}, 32'h5000);

    // Async reset mid-access
    valid_in = 1; acc_cnt_in = 2'd1; rd_mask_in = 2'b00; advance = 1;
    tick(); advance = 0;
    strobes("t8a", 0, 1, 0);
    #2 reset = 1;
    #1;
    strobes("t8rst", 0, 0, 1);
    chk("t8_alu", {16'd0, alu_out}, 0);
    chk("t8_valid", {31'd0, valid_out}, 0);
    chk("t8_rdata", {16'd0, rdata_out}, 0);
    tick(); reset = 0;
    tick();
    strobes("t8post", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
